// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the adder front end: operand classes,
// canonical qNaN and field extraction for any exponent/mantissa split.
package fp_pkg;

  localparam int unsigned FP_MAX_W = 128;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Results are right-aligned in a wide word; callers size-cast to their format.
  function automatic fp_word_t fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    fp_word_t r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

  function automatic logic fp_sign(input fp_word_t x, input int unsigned exp_w,
                                   input int unsigned man_w);
    return x[exp_w+man_w];
  endfunction

  function automatic fp_word_t fp_exp(input fp_word_t x, input int unsigned exp_w,
                                      input int unsigned man_w);
    fp_word_t r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) r[i] = x[man_w+i];
    return r;
  endfunction

  function automatic fp_word_t fp_mant(input fp_word_t x, input int unsigned man_w);
    fp_word_t r;
    r = '0;
    for (int unsigned i = 0; i < man_w; i++) r[i] = x[i];
    return r;
  endfunction

endpackage

// File: rtl/fp_classifier.sv
// Combinational operand classifier; subnormals are reported as zero because
// the adder core assumes an implicit leading one.
module fp_classifier
  import fp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] operand,
  output fp_class_t                         cls
);

  logic [EXP_WIDTH-1:0]      exp_field;
  logic [MANTISSA_WIDTH-1:0] mant_field;

  assign exp_field  = EXP_WIDTH'(fp_exp(fp_word_t'(operand), EXP_WIDTH, MANTISSA_WIDTH));
  assign mant_field = MANTISSA_WIDTH'(fp_mant(fp_word_t'(operand), MANTISSA_WIDTH));

  always_comb begin
    cls = FP_NORMAL;
    if (exp_field == '0) begin
      cls = FP_ZERO;
    end else if (exp_field == '1) begin
      cls = (mant_field == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_add_prep.sv
// Two-stage operand preparation ahead of the FP adder core: sign-applies
// subtraction, resolves special cases and orders operands by magnitude.
module fp_add_prep
  import fp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
  input  logic                              op_in,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_out,
  output logic                              bypass_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] special_out,
  output logic                              invalid_out,
  output logic [15:0]                       bypass_cnt_out
);

  localparam int unsigned W = EXP_WIDTH + MANTISSA_WIDTH + 1;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s2_valid;
  logic         s1_load;
  logic         s2_load;

  fp_class_t    a_cls;
  fp_class_t    b_cls;
  logic         sign_a;
  logic         sign_b;
  logic [W-2:0] mag_a;
  logic [W-2:0] mag_b;
  logic [W-1:0] qnan;

  logic         nxt_bypass;
  logic         nxt_invalid;
  logic [W-1:0] nxt_special;
  logic         swap;

  assign s2_load   = ~s2_valid | ready_in;
  assign s1_load   = ~s1_valid | s2_load;
  assign ready_out = s1_load & ~rst_in;
  assign valid_out = s2_valid;

  fp_classifier #(
    .EXP_WIDTH     (EXP_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_class_a (
    .operand(s1_a),
    .cls    (a_cls)
  );

  fp_classifier #(
    .EXP_WIDTH     (EXP_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_class_b (
    .operand(s1_b),
    .cls    (b_cls)
  );

  assign sign_a = fp_sign(fp_word_t'(s1_a), EXP_WIDTH, MANTISSA_WIDTH);
  assign sign_b = fp_sign(fp_word_t'(s1_b), EXP_WIDTH, MANTISSA_WIDTH);
  assign mag_a  = s1_a[W-2:0];
  assign mag_b  = s1_b[W-2:0];
  assign qnan   = W'(fp_qnan(EXP_WIDTH, MANTISSA_WIDTH));
  assign swap   = mag_b > mag_a;

  // Priority order matters: NaN beats inf-inf, which beats any single inf.
  always_comb begin
    nxt_bypass  = 1'b1;
    nxt_invalid = 1'b0;
    nxt_special = '0;
    if (a_cls == FP_NAN || b_cls == FP_NAN) begin
      nxt_special = qnan;
      nxt_invalid = 1'b1;
    end else if (a_cls == FP_INF && b_cls == FP_INF && sign_a != sign_b) begin
      nxt_special = qnan;
      nxt_invalid = 1'b1;
    end else if (a_cls == FP_INF) begin
      nxt_special = s1_a;
    end else if (b_cls == FP_INF) begin
      nxt_special = s1_b;
    end else if (a_cls == FP_ZERO && b_cls == FP_ZERO) begin
      nxt_special = {sign_a & sign_b, {(W-1){1'b0}}};
    end else if (a_cls == FP_ZERO) begin
      nxt_special = s1_b;
    end else if (b_cls == FP_ZERO) begin
      nxt_special = s1_a;
    end else if (mag_a == mag_b && sign_a != sign_b) begin
      nxt_special = '0;
    end else begin
      nxt_bypass = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_load) begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_a <= a_in;
        s1_b <= {b_in[W-1] ^ op_in, b_in[W-2:0]};
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_valid    <= 1'b0;
      a_out       <= '0;
      b_out       <= '0;
      bypass_out  <= 1'b0;
      special_out <= '0;
      invalid_out <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        a_out       <= swap ? s1_b : s1_a;
        b_out       <= swap ? s1_a : s1_b;
        bypass_out  <= nxt_bypass;
        special_out <= nxt_special;
        invalid_out <= nxt_invalid;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bypass_cnt_out <= '0;
    end else if (s2_valid && ready_in && bypass_out && bypass_cnt_out != '1) begin
      bypass_cnt_out <= bypass_cnt_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_add_prep.sv
// Bench for fp_add_prep: directed special-case, stall and reset steps followed
// by random traffic, all scored against a rule-level reference model.
module tb_fp_add_prep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        op_in = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic        bypass_out;
  logic [31:0] special_out;
  logic        invalid_out;
  logic [15:0] cnt;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] special;
    logic        bypass;
    logic        invalid;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned exp_cnt = 0;
  logic        stalled_prev = 1'b0;
  exp_t        snap;

  fp_add_prep #(
    .EXP_WIDTH     (8),
    .MANTISSA_WIDTH(23)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .a_in          (a_in),
    .b_in          (b_in),
    .op_in         (op_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .a_out         (a_out),
    .b_out         (b_out),
    .bypass_out    (bypass_out),
    .special_out   (special_out),
    .invalid_out   (invalid_out),
    .bypass_cnt_out(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: IEEE-style single-precision rules with subnormals flushed.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b_raw, input logic op);
    exp_t r;
    logic [31:0] b;
    logic na, nb, ia, ib, za, zb;
    b  = b_raw ^ (op ? 32'h8000_0000 : 32'h0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    r = '0;
    if (b[30:0] > a[30:0]) begin
      r.a = b; r.b = a;
    end else begin
      r.a = a; r.b = b;
    end
    r.bypass = 1'b1;
    if (na || nb) begin
      r.special = 32'h7FC0_0000; r.invalid = 1'b1;
    end else if (ia && ib && (a[31] != b[31])) begin
      r.special = 32'h7FC0_0000; r.invalid = 1'b1;
    end else if (ia) r.special = a;
    else if (ib) r.special = b;
    else if (za && zb) r.special = (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
    else if (za) r.special = b;
    else if (zb) r.special = a;
    else if ((a[30:0] == b[30:0]) && (a[31] != b[31])) r.special = 32'h0;
    else r.bypass = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'h00;
      1: r[30:0] = {8'hFF, 23'h0};
      2: begin
        r[30:23] = 8'hFF;
        if (r[22:0] == 0) r[0] = 1'b1;
      end
      3: r[30:23] = 8'h7F;
      default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h80;
    endcase
    return r;
  endfunction

  // One clock: score outputs and capture acceptances at the negedge, then
  // return 1 time unit after the following rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    check("bypass_cnt", {16'h0, cnt}, exp_cnt);
    if (stalled_prev) begin
      check("hold_valid", {31'h0, valid_out}, 32'h1);
      check("hold_a", a_out, snap.a);
      check("hold_b", b_out, snap.b);
      check("hold_special", special_out, snap.special);
      check("hold_bypass", {31'h0, bypass_out}, {31'h0, snap.bypass});
    end
    if (valid_out && ready_in) begin
      if (q.size() == 0) begin
        check("spurious_out", {31'h0, valid_out}, 32'h0);
      end else begin
        e = q.pop_front();
        check("a_out", a_out, e.a);
        check("b_out", b_out, e.b);
        check("bypass", {31'h0, bypass_out}, {31'h0, e.bypass});
        check("special", special_out, e.special);
        check("invalid", {31'h0, invalid_out}, {31'h0, e.invalid});
        if (e.bypass && exp_cnt != 32'hFFFF) exp_cnt++;
      end
    end
    stalled_prev = valid_out && !ready_in;
    snap = '{a: a_out, b: b_out, special: special_out, bypass: bypass_out, invalid: invalid_out};
    if (valid_in && ready_out) q.push_back(model(a_in, b_in, op_in));
    @(posedge clk);
    #1;
  endtask

  // Requires an empty pipeline and ready_in=1.
  task automatic lat_test(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] exp_special);
    valid_in = 1'b1; a_in = a; b_in = b; op_in = op;
    step();
    valid_in = 1'b0;
    check("lat_cycle1_valid", {31'h0, valid_out}, 32'h0);
    step();
    check("lat_cycle2_valid", {31'h0, valid_out}, 32'h1);
    check("lat_special", special_out, exp_special);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    check("drain_empty", 32'(q.size()), 32'h0);
  endtask

  logic [31:0] stall_a[4] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h7F80_0000};
  logic [31:0] stall_b[4] = '{32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 32'h4120_0000};

  initial begin
    int idx;
    #1;
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_ready", {31'h0, ready_out}, 32'h0);
    check("rst_a", a_out, 32'h0);
    check("rst_b", b_out, 32'h0);
    check("rst_special", special_out, 32'h0);
    check("rst_bypass", {31'h0, bypass_out}, 32'h0);
    check("rst_invalid", {31'h0, invalid_out}, 32'h0);
    check("rst_cnt", {16'h0, cnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_in = 1'b1;

    lat_test(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0);
    lat_test(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0);
    check("cnt_after_cancel", {16'h0, cnt}, 32'h1);
    lat_test(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000);
    lat_test(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
    lat_test(32'h0000_0000, 32'hC040_0000, 1'b1, 32'h4040_0000);

    // Stall: four pairs offered back to back while downstream is blocked.
    ready_in = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      valid_in = (idx < 4);
      a_in = stall_a[idx % 4]; b_in = stall_b[idx % 4]; op_in = 1'b0;
      if (valid_in && ready_out) begin
        step(); idx++;
      end else step();
    end
    check("stall_accepts", 32'(idx), 32'd2);
    check("stall_ready_low", {31'h0, ready_out}, 32'h0);
    ready_in = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      valid_in = 1'b1;
      a_in = stall_a[idx]; b_in = stall_b[idx]; op_in = 1'b0;
      if (ready_out) begin
        step(); idx++;
      end else step();
    end
    valid_in = 1'b0;
    check("stall_all_sent", 32'(idx), 32'd4);
    drain();

    // Mid-flight reset with two packets in the pipe.
    valid_in = 1'b1; a_in = 32'h4000_0000; b_in = 32'h4000_0000; op_in = 1'b1;
    step();
    a_in = 32'h3F80_0000; b_in = 32'h4080_0000; op_in = 1'b0;
    step();
    valid_in = 1'b0;
    check("pre_rst_valid", {31'h0, valid_out}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", {31'h0, valid_out}, 32'h0);
    check("midrst_cnt", {16'h0, cnt}, 32'h0);
    check("midrst_ready", {31'h0, ready_out}, 32'h0);
    q.delete();
    exp_cnt = 0;
    stalled_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step();
    lat_test(32'h4120_0000, 32'h3F00_0000, 1'b1, 32'h0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      a_in = rand_op();
      b_in = ($urandom_range(0, 4) == 0) ? (a_in ^ ($urandom_range(0, 1) != 0 ? 32'h8000_0000 : 32'h0))
                                         : rand_op();
      op_in = ($urandom_range(0, 1) != 0);
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    drain();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
